// File: rtl/fir_sched_pkg.sv
// fir_sched_pkg: shared types and constants for the stereo FIR channel scheduler
package fir_sched_pkg;
    localparam int DATA_W_DEF = 24;
    localparam int CH_L = 0;
    localparam int CH_R = 1;
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_e;
endpackage

// File: rtl/fir_sched_fifo.sv
// fir_sched_fifo: per-channel sync FIFO; push on full is accepted when a pop frees a slot the same cycle
//   clk, rst : clock, sync active-high reset
//   push/din : write strobe and data
//   pop      : read strobe, dout is the current head
//   full/empty : occupancy flags
module fir_sched_fifo #(
    parameter int DATA_W  = 24,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 2 ** FIFO_AW;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_q, rd_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               push_ok, pop_ok;
    assign full    = cnt_q == (FIFO_AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= push_ok ? wr_q + FIFO_AW'(1) : wr_q;
            rd_q  <= pop_ok ? rd_q + FIFO_AW'(1) : rd_q;
            cnt_q <= cnt_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/fir_ch_scheduler.sv
// fir_ch_scheduler: buffers L/R codec samples and issues them one at a time, round-robin, to a shared FIR
//   clk, rst        : clock, sync active-high reset
//   in_valid/in_data: per-channel sample strobes ([0]=L, [1]=R) and shared sample
//   fir_din_valid/fir_din : one-hot single-cycle issue strobe and sample (sample held between issues)
//   fir_dout_valid  : FIR completion per channel
//   busy            : FIR owned (pop cycle, issue, in flight)
//   ovf, timeout_err: sticky drop and completion-timeout flags
//   FIR_SCHED_STATS_EN adds drop_cnt_l, drop_cnt_r (saturating) and issue_cnt (wrapping)
module fir_ch_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FIFO_AW  = 2,
    parameter int BUSY_MAX = 300,
    parameter int TO_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [1:0]        fir_din_valid,
    output logic [DATA_W-1:0] fir_din,
    input  logic [1:0]        fir_dout_valid,
    output logic              busy,
    output logic [1:0]        ovf,
    output logic              timeout_err
`ifdef FIR_SCHED_STATS_EN
    ,
    output logic [15:0]       drop_cnt_l,
    output logic [15:0]       drop_cnt_r,
    output logic [31:0]       issue_cnt
`endif
);
    state_e            state_q, state_d;
    logic              sel_q, sel_d, last_q, last_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [1:0]        ovf_q, ovf_d;
    logic              terr_q, terr_d;
    logic [DATA_W-1:0] f_dout [2];
    logic [1:0]        f_full, f_empty, pop, drop;
    for (genvar c = 0; c < 2; c++) begin : g_fifo
        fir_sched_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (in_valid[c]),
            .din  (in_data),
            .pop  (pop[c]),
            .dout (f_dout[c]),
            .full (f_full[c]),
            .empty(f_empty[c])
        );
    end
    // a pop in the same cycle frees a slot, so only an unpopped full FIFO drops
    assign drop        = in_valid & f_full & ~pop;
    assign ovf_d       = ovf_q | drop;
    assign busy        = (state_q != IDLE) || (|pop);
    assign fir_din     = din_q;
    assign ovf         = ovf_q;
    assign timeout_err = terr_q;
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        din_d         = din_q;
        to_d          = to_q;
        terr_d        = terr_q;
        pop           = 2'b00;
        fir_din_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (!(&f_empty)) begin
                    // both pending: take the channel not granted last; else whichever has data
                    sel_d      = (!f_empty[CH_L] && !f_empty[CH_R]) ? ~last_q : !f_empty[CH_R];
                    pop[sel_d] = 1'b1;
                    din_d      = f_dout[sel_d];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                fir_din_valid[sel_q] = 1'b1;
                to_d                 = '0;
                state_d              = BUSY;
            end
            BUSY: begin
                to_d = (to_q == TO_W'(BUSY_MAX)) ? to_q : to_q + TO_W'(1);
                if (fir_dout_valid[sel_q]) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                end else if (to_q == TO_W'(BUSY_MAX - 1)) begin
                    // BUSY_MAX cycles after issue: abandon the channel but still advance round-robin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                    last_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'(CH_L);
            din_q   <= '0;
            to_q    <= '0;
            ovf_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            din_q   <= din_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            terr_q  <= terr_d;
        end
    end
`ifdef FIR_SCHED_STATS_EN
    logic [15:0] drop_l_q, drop_r_q;
    logic [31:0] issue_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_l_q <= '0;
            drop_r_q <= '0;
            issue_q  <= '0;
        end else begin
            drop_l_q <= (drop[CH_L] && drop_l_q != 16'hFFFF) ? drop_l_q + 16'd1 : drop_l_q;
            drop_r_q <= (drop[CH_R] && drop_r_q != 16'hFFFF) ? drop_r_q + 16'd1 : drop_r_q;
            issue_q  <= (state_q == ISSUE) ? issue_q + 32'd1 : issue_q;
        end
    end
    assign drop_cnt_l = drop_l_q;
    assign drop_cnt_r = drop_r_q;
    assign issue_cnt  = issue_q;
`endif
endmodule
